// File: rtl/jk_bank_sequencer_pkg.sv
// Shared encodings for the JK bank sequencer: command opcodes and FSM states.
package jk_bank_sequencer_pkg;

    typedef enum logic [1:0] {
        OpClear = 2'b00,
        OpLoad  = 2'b01,
        OpUp    = 2'b10,
        OpDown  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StInit  = 2'b00,
        StIdle  = 2'b01,
        StExec  = 2'b10,
        StCheck = 2'b11
    } state_e;

endpackage

// File: rtl/jk_toggle_mask.sv
// Toggle vector for a ripple count of the JK bank: bit i flips when all lower bits
// are 1 (counting up) or all lower bits are 0 (counting down).
module jk_toggle_mask #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_shadow,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_toggle
);

    logic [WIDTH-1:0] w_carry_bits;

    // i_dir=1 counts down, so a bit propagates the borrow when it is 0
    assign w_carry_bits = i_dir ? ~i_shadow : i_shadow;

    always_comb begin
        o_toggle    = '0;
        o_toggle[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            o_toggle[i] = o_toggle[i-1] & w_carry_bits[i-1];
        end
    end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Drives J/K of an external JK bank to clear, load or count it, keeps a shadow of the
// expected value and flags a sticky error when the bank disagrees at the check step.
module jk_bank_sequencer
    import jk_bank_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    output logic [WIDTH-1:0] j_o,
    output logic [WIDTH-1:0] k_o,
    input  logic [WIDTH-1:0] q_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    state_e           r_state;
    state_e           w_state_next;
    op_e              r_op;
    op_e              w_op_next;
    logic [WIDTH-1:0] r_arg;
    logic [WIDTH-1:0] w_arg_next;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] w_shadow_next;
    logic [WIDTH-1:0] r_steps;
    logic [WIDTH-1:0] w_steps_next;
    logic             r_err;
    logic             w_err_next;
    logic [WIDTH-1:0] w_toggle;

    jk_toggle_mask #(
        .WIDTH (WIDTH)
    ) u_toggle_mask (
        .i_shadow (r_shadow),
        .i_dir    (r_op == OpDown),
        .o_toggle (w_toggle)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StInit;
            r_op     <= OpClear;
            r_arg    <= '0;
            r_shadow <= '0;
            r_steps  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_op     <= w_op_next;
            r_arg    <= w_arg_next;
            r_shadow <= w_shadow_next;
            r_steps  <= w_steps_next;
            r_err    <= w_err_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_op_next     = r_op;
        w_arg_next    = r_arg;
        w_shadow_next = r_shadow;
        w_steps_next  = r_steps;
        w_err_next    = r_err;
        unique case (r_state)
            StInit: begin
                w_state_next = StIdle;
            end
            StIdle: begin
                if (cmd_valid) begin
                    w_op_next  = op_e'(cmd_op);
                    w_arg_next = cmd_arg;
                    if (op_e'(cmd_op) == OpClear || op_e'(cmd_op) == OpLoad) begin
                        w_steps_next = WIDTH'(1);
                        w_state_next = StExec;
                    end else if (cmd_arg != '0) begin
                        w_steps_next = cmd_arg;
                        w_state_next = StExec;
                    end else begin
                        w_state_next = StCheck;
                    end
                end
            end
            StExec: begin
                unique case (r_op)
                    OpClear: w_shadow_next = '0;
                    OpLoad:  w_shadow_next = r_arg;
                    OpUp:    w_shadow_next = r_shadow + WIDTH'(1);
                    OpDown:  w_shadow_next = r_shadow - WIDTH'(1);
                endcase
                w_steps_next = r_steps - WIDTH'(1);
                if (r_steps == WIDTH'(1)) begin
                    w_state_next = StCheck;
                end
            end
            StCheck: begin
                if (q_i != r_shadow) begin
                    w_err_next = 1'b1;
                end
                w_state_next = StIdle;
            end
        endcase
    end

    // J/K are decoded straight from state so the bank and shadow move on the same edge
    always_comb begin
        j_o       = '0;
        k_o       = '0;
        cmd_ready = 1'b0;
        busy_o    = 1'b1;
        done_o    = 1'b0;
        unique case (r_state)
            StInit: begin
                k_o = '1;
            end
            StIdle: begin
                cmd_ready = 1'b1;
                busy_o    = 1'b0;
            end
            StExec: begin
                unique case (r_op)
                    OpClear: k_o = '1;
                    OpLoad: begin
                        j_o = r_arg;
                        k_o = ~r_arg;
                    end
                    OpUp, OpDown: begin
                        j_o = w_toggle;
                        k_o = w_toggle;
                    end
                endcase
            end
            StCheck: begin
                done_o = 1'b1;
            end
        endcase
    end

    assign err_o = r_err;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Bench for jk_bank_sequencer: a behavioural JK bank, directed vector table, randomized
// commands against an arithmetic model, plus fault-injection and mid-command reset.
module tb_jk_bank_sequencer;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_arg;
    logic [W-1:0] j_o;
    logic [W-1:0] k_o;
    logic [W-1:0] q_i;
    logic         busy_o;
    logic         done_o;
    logic         err_o;

    logic [W-1:0] bank_q;
    logic         bank_set;
    logic [W-1:0] fault_mask;

    int           n_vec  = 0;
    int           n_miss = 0;
    logic [W-1:0] m_val;
    logic         m_err;

    jk_bank_sequencer #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .j_o       (j_o),
        .k_o       (k_o),
        .q_i       (q_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    // Behavioural JK bank with no reset; bank_set forces it to all ones
    always @(posedge clk or posedge bank_set) begin
        if (bank_set) begin
            bank_q <= '1;
        end else begin
            for (int i = 0; i < W; i++) begin
                case ({j_o[i], k_o[i]})
                    2'b01:   bank_q[i] <= 1'b0;
                    2'b10:   bank_q[i] <= 1'b1;
                    2'b11:   bank_q[i] <= ~bank_q[i];
                    default: ;
                endcase
            end
        end
    end

    assign q_i = bank_q & ~fault_mask;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] arg;
        logic [W-1:0] exp_j;
        logic [W-1:0] exp_k;
        logic [W-1:0] exp_q;
        int           exp_lat;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bank value after n cycles of executing a command starting from v0
    function automatic logic [W-1:0] apply(input logic [W-1:0] v0, input logic [1:0] op,
                                           input logic [W-1:0] arg, input int n);
        int done_steps;
        done_steps = (n < int'(arg)) ? n : int'(arg);
        case (op)
            2'd0:    return (n >= 1) ? '0 : v0;
            2'd1:    return (n >= 1) ? arg : v0;
            2'd2:    return W'(int'(v0) + done_steps);
            default: return W'(int'(v0) - done_steps);
        endcase
    endfunction

    function automatic int lat_of(input logic [1:0] op, input logic [W-1:0] arg);
        if (op < 2'd2) return 2;
        return (arg == '0) ? 1 : int'(arg) + 1;
    endfunction

    task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] arg, input logic junk,
                          input logic chk_jk, input logic [W-1:0] exp_j,
                          input logic [W-1:0] exp_k, input logic [W-1:0] exp_q,
                          input int exp_lat);
        int           n;
        int           lat;
        logic [W-1:0] v0;
        n = 0;
        while (!cmd_ready && n < 40) begin
            step();
            n++;
        end
        chk("ready_before_cmd", cmd_ready, 1);
        v0        = m_val;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        step();
        lat = 1;
        if (junk) begin
            cmd_op  = 2'($urandom_range(0, 3));
            cmd_arg = W'($urandom_range(0, 15));
        end else begin
            cmd_valid = 1'b0;
        end
        if (chk_jk) begin
            chk("j_first", j_o, exp_j);
            chk("k_first", k_o, exp_k);
        end
        while (!done_o && lat < 40) begin
            chk("q_trace", bank_q, apply(v0, op, arg, lat - 1));
            step();
            lat++;
        end
        chk("latency", lat, exp_lat);
        m_val = apply(v0, op, arg, 64);
        chk("q_done_model", bank_q, m_val);
        chk("q_done_expected", bank_q, exp_q);
        chk("jk_zero_at_done", {j_o, k_o}, 0);
        if ((m_val & fault_mask) != '0) m_err = 1'b1;
        cmd_valid = 1'b0;
        step();
        chk("err_after_check", err_o, m_err);
        chk("done_single_pulse", done_o, 0);
        chk("idle_after_check", cmd_ready, 1);
    endtask

    vec_t tbl[7];

    initial begin
        int saw_done;
        logic [1:0]   r_op;
        logic [W-1:0] r_arg;

        tbl[0] = '{2'd1, 4'b1010, 4'b1010, 4'b0101, 4'b1010, 2};
        tbl[1] = '{2'd1, 4'b1110, 4'b1110, 4'b0001, 4'b1110, 2};
        tbl[2] = '{2'd2, 4'd3,    4'b0001, 4'b0001, 4'b0001, 4};
        tbl[3] = '{2'd1, 4'b0001, 4'b0001, 4'b1110, 4'b0001, 2};
        tbl[4] = '{2'd3, 4'd2,    4'b0001, 4'b0001, 4'b1111, 3};
        tbl[5] = '{2'd2, 4'd0,    4'b0000, 4'b0000, 4'b1111, 1};
        tbl[6] = '{2'd0, 4'b0110, 4'b0000, 4'b1111, 4'b0000, 2};

        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = '0;
        cmd_arg    = '0;
        fault_mask = '0;
        bank_set   = 1'b0;
        m_val      = '0;
        m_err      = 1'b0;
        #1 bank_set = 1'b1;
        #1 bank_set = 1'b0;

        // Reset state and bank initialisation
        chk("rst_busy", busy_o, 1);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_k_clear", k_o, 4'hF);
        chk("rst_j_zero", j_o, 0);
        step();
        step();
        chk("bank_cleared_in_reset", bank_q, 0);
        #3 bank_set = 1'b1;
        #1 bank_set = 1'b0;
        #1 rst_n = 1'b1;
        chk("init_k_clear", k_o, 4'hF);
        chk("init_ready", cmd_ready, 0);
        step();
        chk("init_bank_q", bank_q, 0);
        chk("init_then_ready", cmd_ready, 1);
        chk("init_err", err_o, 0);
        chk("idle_busy", busy_o, 0);

        for (int i = 0; i < 7; i++) begin
            do_cmd(tbl[i].op, tbl[i].arg, 1'b0, 1'b1, tbl[i].exp_j, tbl[i].exp_k,
                   tbl[i].exp_q, tbl[i].exp_lat);
        end

        for (int i = 0; i < 40; i++) begin
            r_op  = 2'($urandom_range(0, 3));
            r_arg = W'($urandom_range(0, 15));
            do_cmd(r_op, r_arg, 1'($urandom_range(0, 1)), 1'b0, '0, '0,
                   apply(m_val, r_op, r_arg, 64), lat_of(r_op, r_arg));
        end

        // Corrupted feedback sets the sticky error; a good command does not clear it
        fault_mask = 4'b0001;
        do_cmd(2'd1, 4'b0001, 1'b0, 1'b1, 4'b0001, 4'b1110, 4'b0001, 2);
        chk("err_set_by_fault", err_o, 1);
        fault_mask = '0;
        do_cmd(2'd1, 4'b0110, 1'b0, 1'b1, 4'b0110, 4'b1001, 4'b0110, 2);
        chk("err_sticky", err_o, 1);

        // Reset in the middle of a long count, with a competing command held valid
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_arg   = 4'd10;
        step();
        cmd_op    = 2'd1;
        cmd_arg   = 4'b0101;
        step();
        step();
        step();
        chk("mid_count_q", bank_q, 4'b1001);
        chk("held_valid_ignored_busy", busy_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy_o, 1);
        chk("abort_ready", cmd_ready, 0);
        chk("abort_done", done_o, 0);
        chk("abort_err_cleared", err_o, 0);
        chk("abort_k_clear", k_o, 4'hF);
        chk("abort_j_zero", j_o, 0);
        m_val = '0;
        m_err = 1'b0;
        saw_done = 0;
        step();
        if (done_o) saw_done = 1;
        cmd_valid = 1'b0;
        #2 rst_n = 1'b1;
        step();
        chk("abort_bank_q", bank_q, 0);
        chk("abort_then_ready", cmd_ready, 1);
        for (int i = 0; i < 12; i++) begin
            if (done_o) saw_done = 1;
            step();
        end
        chk("no_done_after_abort", saw_done, 0);

        for (int i = 0; i < 8; i++) begin
            r_op  = 2'($urandom_range(0, 3));
            r_arg = W'($urandom_range(0, 15));
            do_cmd(r_op, r_arg, 1'b1, 1'b0, '0, '0,
                   apply(m_val, r_op, r_arg, 64), lat_of(r_op, r_arg));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
